// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: per-button sync/debounce/edge-detect feeding the
// clear/run/pause state machine that drives the seconds counter enable.
module stopwatch_ctrl #(
    parameter int unsigned DEB_CYCLES = 20000,
    parameter int unsigned DEB_W      = 15
) (
    input  logic       clk,
    input  logic       hard_reset,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic [1:0] en,
    output logic       running,
    output logic       cleared
);

    localparam int unsigned     N_BTN    = 2;
    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_CLEARED = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10
    } state_t;

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] pulse_c;
    logic             ss_c;
    logic             clr_c;

    state_t     state;
    state_t     state_next;
    logic [1:0] en_next;
    logic       running_next;
    logic       cleared_next;

    assign btn_raw = {btn_clear, btn_start_stop};
    assign ss_c    = pulse_c[0];
    assign clr_c   = pulse_c[1];

    // Identical per-button path: 2-flop sync, stable-count debounce, rising-edge event
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic             s1;
        logic             s2;
        logic             deb;
        logic             deb_d;
        logic [DEB_W-1:0] cnt;

        always_ff @(posedge clk or negedge hard_reset) begin
            if (!hard_reset) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                deb   <= 1'b0;
                deb_d <= 1'b0;
                cnt   <= '0;
            end else begin
                s1    <= btn_raw[i];
                s2    <= s1;
                deb_d <= deb;
                if (s2 == deb) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    deb <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + DEB_W'(1);
                end
            end
        end

        assign pulse_c[i] = deb & ~deb_d;
    end

    // State and Moore outputs registered together so en never glitches
    always_ff @(posedge clk or negedge hard_reset) begin
        if (!hard_reset) begin
            state   <= ST_CLEARED;
            en      <= 2'b00;
            running <= 1'b0;
            cleared <= 1'b1;
        end else begin
            state   <= state_next;
            en      <= en_next;
            running <= running_next;
            cleared <= cleared_next;
        end
    end

    // Clear only takes effect from PAUSED, where it outranks start/stop
    always_comb begin
        state_next   = ST_CLEARED;
        en_next      = 2'b00;
        running_next = 1'b0;
        cleared_next = 1'b0;

        case (state)
            ST_CLEARED: state_next = ss_c ? ST_RUNNING : ST_CLEARED;
            ST_RUNNING: state_next = ss_c ? ST_PAUSED : ST_RUNNING;
            ST_PAUSED: begin
                if (clr_c) begin
                    state_next = ST_CLEARED;
                end else if (ss_c) begin
                    state_next = ST_RUNNING;
                end else begin
                    state_next = ST_PAUSED;
                end
            end
            default: state_next = ST_CLEARED;
        endcase

        case (state_next)
            ST_RUNNING: begin
                en_next      = 2'b01;
                running_next = 1'b1;
            end
            ST_PAUSED: en_next = 2'b10;
            default:   cleared_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: each press queues the output change it
// should cause and the cycle it should land on; a monitor pops on every change.
module tb_stopwatch_ctrl;

    localparam int unsigned DEB_CYCLES = 4;
    localparam int unsigned DEB_W      = 3;
    localparam int          LAT        = int'(DEB_CYCLES) + 3;

    // {en, running, cleared}
    localparam logic [3:0] O_CLR = 4'b0001;
    localparam logic [3:0] O_RUN = 4'b0110;
    localparam logic [3:0] O_PAU = 4'b1000;

    logic       clk = 1'b0;
    logic       hard_reset;
    logic       btn_start_stop;
    logic       btn_clear;
    logic [1:0] en;
    logic       running;
    logic       cleared;

    typedef struct {
        int         cyc;
        logic [3:0] out;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_pass   = 0;
    bit         mon_en   = 1'b0;
    logic [3:0] prev     = 4'b0001;

    stopwatch_ctrl #(
        .DEB_CYCLES(DEB_CYCLES),
        .DEB_W     (DEB_W)
    ) dut (
        .clk           (clk),
        .hard_reset    (hard_reset),
        .btn_start_stop(btn_start_stop),
        .btn_clear     (btn_clear),
        .en            (en),
        .running       (running),
        .cleared       (cleared)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Change expected LAT edges after the drive point, plus any extra delay
    task automatic expect_at(input int delay, input logic [3:0] out);
        exp_t e;
        e.cyc = cyc + delay + LAT;
        e.out = out;
        sb_q.push_back(e);
    endtask

    task automatic press(input logic ss, input logic clr, input int hold,
                         input bit has_exp, input logic [3:0] out);
        btn_start_stop = ss;
        btn_clear      = clr;
        if (has_exp) expect_at(0, out);
        tick(hold);
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        tick(10);
    endtask

    // Any output change must match the head of the scoreboard
    always @(negedge clk) begin
        logic [3:0] obs;
        exp_t       e;
        obs = {en, running, cleared};
        if (mon_en && obs !== prev) begin
            if (sb_q.size() == 0) begin
                check("spurious_change", 32'(obs), 32'(prev));
            end else begin
                e = sb_q.pop_front();
                check("change_cycle", 32'(cyc), 32'(e.cyc));
                check("change_value", 32'(obs), 32'(e.out));
            end
            prev = obs;
        end
    end

    initial begin
        bit pat [11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        hard_reset     = 1'b1;
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;

        // Reset values, then idle with buttons low
        #2 hard_reset = 1'b0;
        #1 check("reset_async", 32'({en, running, cleared}), 32'(O_CLR));
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", 32'({en, running, cleared}), 32'(O_CLR));
        end
        @(posedge clk);
        #1 hard_reset = 1'b1;
        prev   = O_CLR;
        mon_en = 1'b1;
        tick(10);
        check("idle_queue", 32'(sb_q.size()), 32'd0);

        // Press latency, long hold gives one event
        press(1'b1, 1'b0, 20, 1'b1, O_RUN);
        check("latency_queue", 32'(sb_q.size()), 32'd0);

        // 3-cycle pulse alone is rejected
        btn_start_stop = 1'b1;
        tick(3);
        btn_start_stop = 1'b0;
        tick(10);
        check("short_pulse_queue", 32'(sb_q.size()), 32'd0);

        // Bounce pattern: only the final stable run (index 5) counts
        expect_at(5, O_PAU);
        for (int k = 0; k < 11; k++) begin
            btn_start_stop = pat[k];
            tick(1);
        end
        tick(10);
        btn_start_stop = 1'b0;
        tick(10);
        check("bounce_queue", 32'(sb_q.size()), 32'd0);

        // Both buttons together in PAUSED: clear wins
        press(1'b1, 1'b1, 10, 1'b1, O_CLR);
        check("simul_queue", 32'(sb_q.size()), 32'd0);

        // Start, clear (ignored while running), stop, clear
        press(1'b1, 1'b0, 10, 1'b1, O_RUN);
        press(1'b0, 1'b1, 10, 1'b0, O_CLR);
        press(1'b1, 1'b0, 10, 1'b1, O_PAU);
        press(1'b0, 1'b1, 10, 1'b1, O_CLR);
        check("full_cycle_queue", 32'(sb_q.size()), 32'd0);

        // Reset mid-debounce while RUNNING; held button re-debounces afterwards
        press(1'b1, 1'b0, 10, 1'b1, O_RUN);
        btn_start_stop = 1'b1;
        tick(4);
        mon_en     = 1'b0;
        hard_reset = 1'b0;
        #1 check("mid_debounce_reset", 32'({en, running, cleared}), 32'(O_CLR));
        repeat (2) @(posedge clk);
        #1 hard_reset = 1'b1;
        prev   = O_CLR;
        mon_en = 1'b1;
        expect_at(0, O_RUN);
        tick(20);
        btn_start_stop = 1'b0;
        tick(10);
        check("post_reset_queue", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
